// File: rtl/pika_pkg.sv
// Shared constants, state encoding and clamp helper for the pika player controller.
// The DASH encoding exists only when PIKA_DASH_EN is defined.
package pika_pkg;
  localparam int FRAC_W      = 6;
  localparam int SCREEN_W    = 320;
  localparam int FLOOR_Y     = 240;
  localparam int NET_X       = 160;
  localparam int NET_W       = 6;
  localparam int PIKA_W      = 60;
  localparam int PIKA_H      = 60;
  localparam int CNT_W       = 4;
  localparam int DASH_FRAMES = 6;

`ifdef PIKA_DASH_EN
  typedef enum logic [2:0] {
    ST_GROUND  = 3'd0,
    ST_AIR     = 3'd1,
    ST_SMASH   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_DASH    = 3'd4
  } pika_state_e;
`else
  typedef enum logic [2:0] {
    ST_GROUND  = 3'd0,
    ST_AIR     = 3'd1,
    ST_SMASH   = 3'd2,
    ST_RECOVER = 3'd3
  } pika_state_e;
`endif

  function automatic logic [9:0] clamp10(input logic signed [10:0] v,
                                         input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
    if (v < lo)      clamp10 = lo[9:0];
    else if (v > hi) clamp10 = hi[9:0];
    else             clamp10 = v[9:0];
  endfunction
endpackage

// File: rtl/pika_player_ctrl_if.sv
// Frame strobe, button levels and player outputs bundled between stimulus and controller.
interface pika_player_ctrl_if;
  logic       frame_en;
  logic       round_reset;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_smash;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       op_move_left;
  logic       op_move_right;
  logic       op_jump;
  logic       is_smash;
  logic [2:0] state;

  modport master (
    output frame_en, round_reset, btn_left, btn_right, btn_jump, btn_smash,
    input  pos_x, pos_y, op_move_left, op_move_right, op_jump, is_smash, state
  );
  modport slave (
    input  frame_en, round_reset, btn_left, btn_right, btn_jump, btn_smash,
    output pos_x, pos_y, op_move_left, op_move_right, op_jump, is_smash, state
  );
endinterface

// File: rtl/pika_edge_detect.sv
// Frame-qualified rising-edge detector; i_load re-arms the history on round reset
// so a button held across the reset does not fire.
module pika_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_frame_en,
  input  logic i_load,
  input  logic i_lvl,
  output logic o_rise
);
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_prev <= 1'b0;
    else if (i_load | i_frame_en) r_prev <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_prev;
endmodule

// File: rtl/pika_player_ctrl.sv
// Per-player motion controller: buttons -> position, move/jump/smash flags, one step per frame.
// Optional ground dash enabled by defining PIKA_DASH_EN.
module pika_player_ctrl import pika_pkg::*; #(
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 94,
  parameter int INIT_X         = 20,
  parameter int GROUND_Y       = 180,
  parameter int MOVE_STEP      = 2,
  parameter int JUMP_VY        = -448,
  parameter int GRAVITY_AIR    = 16,
  parameter int SMASH_FRAMES   = 8,
  parameter int RECOVER_FRAMES = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  pika_player_ctrl_if.slave  bus
);
  localparam logic signed [10:0] P_XMIN = 11'(X_MIN);
  localparam logic signed [10:0] P_XMAX = 11'(X_MAX);
  localparam logic signed [10:0] P_GY   = 11'(GROUND_Y);
  localparam logic signed [10:0] P_STEP = 11'(MOVE_STEP);
  localparam logic signed [9:0]  P_JVY  = 10'(JUMP_VY);
  localparam logic signed [9:0]  P_GRAV = 10'(GRAVITY_AIR);
  localparam logic [9:0]         P_INIT_X = 10'(INIT_X);
  localparam logic [9:0]         P_GY10   = 10'(GROUND_Y);
  localparam logic [CNT_W-1:0]   P_SMASH_CNT = CNT_W'(SMASH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   P_REC_CNT   = CNT_W'(RECOVER_FRAMES - 1);

  pika_state_e       r_state, w_nx_state;
  logic [9:0]        r_x, r_y, w_nx_x, w_nx_y;
  logic signed [9:0] r_vy, w_nx_vy;
  logic [CNT_W-1:0]  r_cnt, w_nx_cnt;
  logic              r_opl, r_opr, w_nx_opl, w_nx_opr;

  logic              w_jump_rise, w_smash_rise;
  logic              w_cmd_l, w_cmd_r;
  logic signed [10:0] w_dir, w_x_s, w_y_s, w_vy_ext, w_dy, w_y_raw;
  logic signed [9:0]  w_vy_base, w_vy_n;
  logic [9:0]         w_x_mv, w_y_air;
  logic               w_land;

  pika_edge_detect u_ed_jump (
    .clk(clk), .rst_n(rst_n), .i_frame_en(bus.frame_en), .i_load(bus.round_reset),
    .i_lvl(bus.btn_jump), .o_rise(w_jump_rise)
  );
  pika_edge_detect u_ed_smash (
    .clk(clk), .rst_n(rst_n), .i_frame_en(bus.frame_en), .i_load(bus.round_reset),
    .i_lvl(bus.btn_smash), .o_rise(w_smash_rise)
  );

  assign w_cmd_l = bus.btn_left & ~bus.btn_right;
  assign w_cmd_r = bus.btn_right & ~bus.btn_left;
  assign w_dir   = w_cmd_l ? -P_STEP : (w_cmd_r ? P_STEP : 11'sd0);
  assign w_x_s   = {1'b0, r_x};
  assign w_y_s   = {1'b0, r_y};
  assign w_x_mv  = clamp10(w_x_s + w_dir, P_XMIN, P_XMAX);

  // On the takeoff frame gravity is already applied to the launch velocity.
  assign w_vy_base = (r_state == ST_GROUND) ? P_JVY : r_vy;
  assign w_vy_n    = w_vy_base + P_GRAV;
  assign w_vy_ext  = {w_vy_n[9], w_vy_n};
  assign w_dy      = w_vy_ext >>> FRAC_W;
  assign w_y_raw   = w_y_s + w_dy;
  assign w_land    = (w_y_raw >= P_GY);
  assign w_y_air   = clamp10(w_y_raw, 11'sd0, P_GY);

`ifdef PIKA_DASH_EN
  localparam logic signed [10:0] P_DSTEP    = 11'(3 * MOVE_STEP);
  localparam logic [CNT_W-1:0]   P_DASH_CNT = CNT_W'(DASH_FRAMES - 2);
  logic       r_dash_l, w_nx_dash_l, w_dash_l_sel;
  logic [9:0] w_x_dash;
  // Dash direction is latched at entry so releasing the button mid-dash does not stop it.
  assign w_dash_l_sel = (r_state == ST_DASH) ? r_dash_l : w_cmd_l;
  assign w_x_dash     = clamp10(w_x_s + (w_dash_l_sel ? -P_DSTEP : P_DSTEP), P_XMIN, P_XMAX);
`endif

  always_comb begin
    w_nx_state = r_state;
    w_nx_x     = r_x;
    w_nx_y     = r_y;
    w_nx_vy    = r_vy;
    w_nx_cnt   = r_cnt;
    w_nx_opl   = w_cmd_l;
    w_nx_opr   = w_cmd_r;
`ifdef PIKA_DASH_EN
    w_nx_dash_l = r_dash_l;
`endif
    case (r_state)
      ST_GROUND: begin
        w_nx_x = w_x_mv;
        if (w_jump_rise) begin
          w_nx_state = ST_AIR;
          w_nx_vy    = w_vy_n;
          w_nx_y     = w_y_air;
        end
`ifdef PIKA_DASH_EN
        else if (w_smash_rise && (w_cmd_l || w_cmd_r)) begin
          w_nx_state  = ST_DASH;
          w_nx_x      = w_x_dash;
          w_nx_cnt    = P_DASH_CNT;
          w_nx_dash_l = w_cmd_l;
        end
`endif
      end
      ST_AIR: begin
        w_nx_x = w_x_mv;
        if (w_land) begin
          w_nx_state = ST_GROUND;
          w_nx_y     = P_GY10;
          w_nx_vy    = '0;
        end else begin
          w_nx_y  = w_y_air;
          w_nx_vy = w_vy_n;
          if (w_smash_rise) begin
            w_nx_state = ST_SMASH;
            w_nx_cnt   = P_SMASH_CNT;
          end
        end
      end
      ST_SMASH: begin
        w_nx_x = w_x_mv;
        if (w_land) begin
          w_nx_state = ST_RECOVER;
          w_nx_cnt   = P_REC_CNT;
          w_nx_y     = P_GY10;
          w_nx_vy    = '0;
        end else begin
          w_nx_y  = w_y_air;
          w_nx_vy = w_vy_n;
          if (r_cnt == '0) w_nx_state = ST_AIR;
          else             w_nx_cnt   = r_cnt - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        w_nx_opl = 1'b0;
        w_nx_opr = 1'b0;
        if (r_cnt == '0) w_nx_state = ST_GROUND;
        else             w_nx_cnt   = r_cnt - CNT_W'(1);
      end
`ifdef PIKA_DASH_EN
      ST_DASH: begin
        w_nx_x = w_x_dash;
        if (r_cnt == '0) w_nx_state = ST_GROUND;
        else             w_nx_cnt   = r_cnt - CNT_W'(1);
      end
`endif
      default: w_nx_state = ST_GROUND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GROUND;
      r_x     <= P_INIT_X;
      r_y     <= P_GY10;
      r_vy    <= '0;
      r_cnt   <= '0;
      r_opl   <= 1'b0;
      r_opr   <= 1'b0;
    end else if (bus.round_reset) begin
      r_state <= ST_GROUND;
      r_x     <= P_INIT_X;
      r_y     <= P_GY10;
      r_vy    <= '0;
      r_cnt   <= '0;
      r_opl   <= 1'b0;
      r_opr   <= 1'b0;
    end else if (bus.frame_en) begin
      r_state <= w_nx_state;
      r_x     <= w_nx_x;
      r_y     <= w_nx_y;
      r_vy    <= w_nx_vy;
      r_cnt   <= w_nx_cnt;
      r_opl   <= w_nx_opl;
      r_opr   <= w_nx_opr;
    end
  end

`ifdef PIKA_DASH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_dash_l <= 1'b0;
    else if (bus.round_reset) r_dash_l <= 1'b0;
    else if (bus.frame_en)    r_dash_l <= w_nx_dash_l;
  end
`endif

  assign bus.pos_x         = r_x;
  assign bus.pos_y         = r_y;
  assign bus.op_move_left  = r_opl;
  assign bus.op_move_right = r_opr;
  assign bus.op_jump       = (r_state == ST_AIR) || (r_state == ST_SMASH);
  assign bus.is_smash      = (r_state == ST_SMASH);
  assign bus.state         = r_state;
endmodule

// File: tb/tb_pika_player_ctrl.sv
// Scoreboard bench for pika_player_ctrl: driver queues hand-computed expectations,
// monitor compares one cycle after each frame / round reset / snapshot strobe.
module tb_pika_player_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pika_player_ctrl_if bus();

  pika_player_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       l, r, j, s;
    logic [2:0] st;
  } obs_t;

  obs_t  eq[$];
  bit    cq[$];
  string nq[$];

  int   total = 0;
  int   bad   = 0;
  logic snap  = 1'b0;
  logic pend  = 1'b0;
  logic drain_req  = 1'b0;
  logic drain_done = 1'b0;

  always @(posedge clk) pend <= bus.frame_en | bus.round_reset | snap;

  // Monitor
  always @(negedge clk) begin
    obs_t  e, a;
    bit    c;
    string n;
    if (pend) begin
      if (eq.size() == 0) begin
        total++; bad++;
        $display("FAIL underflow: output presented with no expectation queued");
      end else begin
        e = eq.pop_front(); c = cq.pop_front(); n = nq.pop_front();
        if (c) begin
          a = '{x: bus.pos_x, y: bus.pos_y, l: bus.op_move_left, r: bus.op_move_right,
                j: bus.op_jump, s: bus.is_smash, st: bus.state};
          total++;
          if (a !== e) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d l=%0b r=%0b j=%0b s=%0b st=%0d, want x=%0d y=%0d l=%0b r=%0b j=%0b s=%0b st=%0d",
                     n, a.x, a.y, a.l, a.r, a.j, a.s, a.st, e.x, e.y, e.l, e.r, e.j, e.s, e.st);
          end
        end
      end
    end
    if (drain_req && !drain_done) begin
      drain_done = 1'b1;
      total++;
      if (eq.size() != 0) begin
        bad++;
        $display("FAIL drain: pending=%0d want 0", eq.size());
      end
    end
  end

  task automatic btn(input bit l, input bit r, input bit j, input bit s);
    bus.btn_left = l; bus.btn_right = r; bus.btn_jump = j; bus.btn_smash = s;
  endtask

  task automatic push(input bit c, input int x, input int y, input bit l, input bit r,
                      input bit j, input bit s, input int st, input string nm);
    obs_t e;
    e.x = 10'(x); e.y = 10'(y); e.l = l; e.r = r; e.j = j; e.s = s; e.st = 3'(st);
    eq.push_back(e); cq.push_back(c); nq.push_back(nm);
  endtask

  task automatic frm(input bit c, input int x, input int y, input bit l, input bit r,
                     input bit j, input bit s, input int st, input string nm);
    @(negedge clk);
    bus.frame_en = 1'b1;
    push(c, x, y, l, r, j, s, st, nm);
    @(negedge clk);
    bus.frame_en = 1'b0;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) frm(1'b0, 0, 0, 0, 0, 0, 0, 0, "");
  endtask

  task automatic rreset(input int x, input int y, input int st, input string nm);
    @(negedge clk);
    bus.round_reset = 1'b1;
    push(1'b1, x, y, 0, 0, 0, 0, st, nm);
    @(negedge clk);
    bus.round_reset = 1'b0;
  endtask

  task automatic snapshot(input int x, input int y, input bit l, input bit r,
                          input bit j, input bit s, input int st, input string nm);
    @(negedge clk);
    snap = 1'b1;
    push(1'b1, x, y, l, r, j, s, st, nm);
    @(negedge clk);
    snap = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_en = 1'b0; bus.round_reset = 1'b0;
    btn(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snapshot(20, 180, 0, 0, 0, 0, 0, "reset");

    // Full jump arc; apex at frame 28, touchdown on frame 58
    btn(0, 0, 1, 0); frm(1, 20, 173, 0, 0, 1, 0, 1, "t1_jump");
    btn(0, 0, 0, 0); frm(1, 20, 166, 0, 0, 1, 0, 1, "t1_k2");
    skip(25);        frm(1, 20, 75, 0, 0, 1, 0, 1, "t1_apex");
    skip(29);        frm(1, 20, 180, 0, 0, 0, 0, 0, "t1_land");

    // Horizontal clamp and conflicting buttons
    btn(1, 0, 0, 0); frm(1, 18, 180, 1, 0, 0, 0, 0, "t2_left1");
    skip(8);         frm(1, 0, 180, 1, 0, 0, 0, 0, "t2_left10");
    skip(4);         frm(1, 0, 180, 1, 0, 0, 0, 0, "t2_clamp");
    btn(1, 1, 0, 0); frm(1, 0, 180, 0, 0, 0, 0, 0, "t2_both");
    btn(0, 1, 0, 0); skip(49);
    frm(1, 94, 180, 0, 1, 0, 0, 0, "t2_rclamp");
    btn(0, 0, 0, 0); frm(1, 94, 180, 0, 0, 0, 0, 0, "t2_idle");

    // Smash on frame 3 lasts 8 frames, then AIR, then normal landing
    btn(0, 0, 1, 0); frm(1, 94, 173, 0, 0, 1, 0, 1, "t3_k1");
    btn(0, 0, 0, 0); skip(1);
    btn(0, 0, 0, 1); frm(1, 94, 159, 0, 0, 1, 1, 2, "t3_smash");
    skip(1);
    btn(0, 0, 0, 0); skip(5);
    frm(1, 94, 120, 0, 0, 1, 1, 2, "t3_smash8");
    frm(1, 94, 115, 0, 0, 1, 0, 1, "t3_air");
    skip(46);        frm(1, 94, 180, 0, 0, 0, 0, 0, "t3_land");

    // Late smash lands in SMASH -> 12 frozen RECOVER frames
    btn(0, 0, 1, 0); frm(1, 94, 173, 0, 0, 1, 0, 1, "t4_k1");
    btn(0, 0, 0, 0); skip(50);
    btn(0, 0, 0, 1); frm(1, 94, 141, 0, 0, 1, 1, 2, "t4_smash");
    btn(0, 0, 0, 0); skip(5);
    frm(1, 94, 180, 0, 0, 0, 0, 3, "t4_land_rec");
    btn(1, 0, 0, 0); frm(1, 94, 180, 0, 0, 0, 0, 3, "t4_rec_hold");
    skip(9);         frm(1, 94, 180, 0, 0, 0, 0, 3, "t4_rec_last");
    frm(1, 94, 180, 0, 0, 0, 0, 0, "t4_ground");
    frm(1, 92, 180, 1, 0, 0, 0, 0, "t4_move");
    btn(0, 0, 0, 0);

    // round_reset mid-air with jump held; no retrigger until release+press
    btn(0, 0, 1, 0); frm(1, 92, 173, 0, 0, 1, 0, 1, "t5_k1");
    skip(4);
    rreset(20, 180, 0, "t5_rreset");
    frm(1, 20, 180, 0, 0, 0, 0, 0, "t5_held");
    skip(1);
    btn(0, 0, 0, 0); frm(1, 20, 180, 0, 0, 0, 0, 0, "t5_release");
    btn(0, 0, 1, 0); frm(1, 20, 173, 0, 0, 1, 0, 1, "t5_rejump");
    btn(1, 0, 0, 1); repeat (5) @(negedge clk);
    snapshot(20, 173, 0, 0, 1, 0, 1, "t5_hold");
    btn(0, 0, 0, 0); skip(56);
    frm(1, 20, 180, 0, 0, 0, 0, 0, "t5_land");

`ifdef PIKA_DASH_EN
    btn(0, 1, 0, 1); frm(1, 26, 180, 0, 1, 0, 0, 4, "t6_d1");
    btn(0, 1, 0, 0); skip(1);
    frm(1, 38, 180, 0, 1, 0, 0, 4, "t6_d3");
    skip(2);
    frm(1, 56, 180, 0, 1, 0, 0, 0, "t6_d6");
    frm(1, 58, 180, 0, 1, 0, 0, 0, "t6_after");
`else
    btn(0, 1, 0, 1); frm(1, 22, 180, 0, 1, 0, 0, 0, "t6_nodash");
    btn(0, 1, 0, 0); frm(1, 24, 180, 0, 1, 0, 0, 0, "t6_walk");
`endif
    btn(0, 0, 0, 0);

    for (int i = 0; i < 50 && eq.size() != 0; i++) @(negedge clk);
    drain_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
